// File: rtl/counter_pkg.sv
// Shared constants and encodings for the cascaded up/down digit counter.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  typedef enum logic [1:0] {
    DIR_HOLD = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

  // Bounds for a plain decimal digit and for the tens-of-minutes digit
  localparam logic [3:0] DEC_UPPER      = 4'd9;
  localparam logic [3:0] DEC_LOWER      = 4'd0;
  localparam logic [3:0] MIN_TENS_UPPER = 4'd5;
  localparam logic [3:0] MIN_TENS_LOWER = 4'd0;

endpackage

// File: rtl/digit_cell.sv
// One combinational counter digit: bound detection and next-value selection.
module digit_cell
  import counter_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] i_d,
  input  logic               i_en,
  input  dir_e               i_dir,
  input  logic [DIGIT_W-1:0] i_upper,
  input  logic [DIGIT_W-1:0] i_lower,
  input  logic [DIGIT_W-1:0] i_up_init,
  input  logic [DIGIT_W-1:0] i_dn_init,
  output logic               o_at_top,
  output logic               o_at_bot,
  output logic [DIGIT_W-1:0] o_next
);

  localparam logic [DIGIT_W-1:0] ONE = {{(DIGIT_W-1){1'b0}}, 1'b1};

  // Inclusive compares so an out-of-range digit behaves as if at the bound
  assign o_at_top = (i_d >= i_upper);
  assign o_at_bot = (i_d <= i_lower);

  always_comb begin
    o_next = i_d;
    if (i_en) begin
      case (i_dir)
        DIR_UP:  o_next = o_at_top ? i_up_init : (i_d + ONE);
        DIR_DN:  o_next = o_at_bot ? i_dn_init : (i_d - ONE);
        default: o_next = i_d;
      endcase
    end
  end

endmodule

// File: rtl/multi_digit_updown_counter.sv
// Cascade of DIGITS up/down digits with a one-cycle ripple carry/borrow chain,
// synchronous load, wrap/saturate mode, carry/borrow pulses and sticky flags.
module multi_digit_updown_counter
  import counter_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       increase,
  input  logic                       decrease,
  input  logic                       load,
  input  logic [DIGITS*DIGIT_W-1:0]  load_value,
  input  logic                       mode_saturate,
  input  logic                       clear_flags,
  input  logic [DIGITS*DIGIT_W-1:0]  upper_bound,
  input  logic [DIGITS*DIGIT_W-1:0]  lower_bound,
  input  logic [DIGITS*DIGIT_W-1:0]  up_initial_value,
  input  logic [DIGITS*DIGIT_W-1:0]  down_initial_value,
  input  logic [DIGITS*DIGIT_W-1:0]  rst_value,
  output logic [DIGITS*DIGIT_W-1:0]  value,
  output logic                       carry_out,
  output logic                       borrow_out,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int W = DIGITS * DIGIT_W;

  logic [W-1:0]      r_value;
  logic              r_carry;
  logic              r_borrow;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_step_up;
  logic              w_step_dn;
  dir_e              w_dir;
  logic [DIGITS-1:0] w_en;
  logic [DIGITS-1:0] w_at_top;
  logic [DIGITS-1:0] w_at_bot;
  logic [DIGITS-1:0] w_at_bound;
  logic [W-1:0]      w_next;
  logic              w_ovf_set;
  logic              w_unf_set;
  logic              w_sat_hold;

  assign w_step_up = increase & ~decrease;
  assign w_step_dn = decrease & ~increase;

  always_comb begin
    w_dir = DIR_HOLD;
    if (w_step_up)      w_dir = DIR_UP;
    else if (w_step_dn) w_dir = DIR_DN;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    digit_cell #(.DIGIT_W(DIGIT_W)) u_cell (
      .i_d       (r_value[g*DIGIT_W +: DIGIT_W]),
      .i_en      (w_en[g]),
      .i_dir     (w_dir),
      .i_upper   (upper_bound[g*DIGIT_W +: DIGIT_W]),
      .i_lower   (lower_bound[g*DIGIT_W +: DIGIT_W]),
      .i_up_init (up_initial_value[g*DIGIT_W +: DIGIT_W]),
      .i_dn_init (down_initial_value[g*DIGIT_W +: DIGIT_W]),
      .o_at_top  (w_at_top[g]),
      .o_at_bot  (w_at_bot[g]),
      .o_next    (w_next[g*DIGIT_W +: DIGIT_W])
    );

    assign w_at_bound[g] = (w_dir == DIR_UP) ? w_at_top[g] : w_at_bot[g];

    // A digit advances only when every less significant digit is rolling over
    if (g == 0) begin : g_en0
      assign w_en[g] = w_step_up | w_step_dn;
    end else begin : g_enn
      assign w_en[g] = w_en[g-1] & w_at_bound[g-1];
    end
  end

  assign w_ovf_set  = ~load & w_step_up & (&w_at_top);
  assign w_unf_set  = ~load & w_step_dn & (&w_at_bot);
  assign w_sat_hold = (mode_saturate == MODE_SAT) & (w_ovf_set | w_unf_set);

  // rst_value is a live input, so reset re-samples it on every clock while low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value     <= rst_value;
      r_carry     <= 1'b0;
      r_borrow    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_carry     <= w_ovf_set & (mode_saturate == MODE_WRAP);
      r_borrow    <= w_unf_set & (mode_saturate == MODE_WRAP);
      r_overflow  <= w_ovf_set | (r_overflow & ~clear_flags);
      r_underflow <= w_unf_set | (r_underflow & ~clear_flags);
      if (load) begin
        r_value <= load_value;
      end else if (!w_sat_hold) begin
        r_value <= w_next;
      end
    end
  end

  assign value      = r_value;
  assign carry_out  = r_carry;
  assign borrow_out = r_borrow;
  assign overflow   = r_overflow;
  assign underflow  = r_underflow;

endmodule
